w_74hc191_counter: RTL and testbench



---
 rtl/w_74hc191_counter.sv | 50 +++++
 tb/tb_w_74hc191_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/w_74hc191_counter.sv
// Presettable synchronous up/down counter (74HC191 style) feeding the AND-array A bus.
// Latency: q updates one edge after load/cten; max_min/rco are combinational. No backpressure.
module w_74hc191_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             cten,
    input  logic             down,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             max_min,
    output logic             rco
);

    localparam int unsigned TOP_INT = MODULUS - 1;
    localparam logic [WIDTH-1:0] TOP  = TOP_INT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] q_nxt;

    // Out-of-range values wrap to 0 going up, and walk back into range going down.
    always_comb begin
        q_nxt = q;
        if (load) begin
            q_nxt = d;
        end else if (cten) begin
            if (down) begin
                q_nxt = (q == ZERO) ? TOP : (q - ONE);
            end else begin
                q_nxt = (q >= TOP) ? ZERO : (q + ONE);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= ZERO;
        end else begin
            q <= q_nxt;
        end
    end

    assign max_min = down ? (q == ZERO) : (q == TOP);
    assign rco     = max_min & cten;

endmodule

// File: tb/tb_w_74hc191_counter.sv
// Bench for w_74hc191_counter: a MODULUS=16 and a MODULUS=10 instance on shared stimulus.
module tb_w_74hc191_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       load, cten, down;
    logic [3:0] d;
    logic [3:0] q16, q10;
    logic       mm16, mm10, rco16, rco10;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    w_74hc191_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
        .clk(clk), .rst(rst), .load(load), .cten(cten), .down(down), .d(d),
        .q(q16), .max_min(mm16), .rco(rco16)
    );

    w_74hc191_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
        .clk(clk), .rst(rst), .load(load), .cten(cten), .down(down), .d(d),
        .q(q10), .max_min(mm10), .rco(rco10)
    );

    typedef struct packed {
        logic       inst;   // 0 = MODULUS 16, 1 = MODULUS 10
        logic       load;
        logic       cten;
        logic       down;
        logic [3:0] d;
        logic [3:0] q;
        logic       mm;
        logic       rco;
    } vec_t;

    typedef struct {
        logic       inst;
        logic [3:0] q;
        logic       mm;
        logic       rco;
        string      name;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[25];

    function automatic vec_t mk(input logic inst, input logic ld, input logic ce, input logic dn,
                                input logic [3:0] dd, input logic [3:0] eq,
                                input logic em, input logic er);
        vec_t v;
        v.inst = inst; v.load = ld; v.cten = ce; v.down = dn; v.d = dd;
        v.q = eq; v.mm = em; v.rco = er;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic [3:0] act, input logic [3:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        logic [3:0] aq;
        logic am, ar;
        e  = sbq.pop_front();
        aq = e.inst ? q10  : q16;
        am = e.inst ? mm10 : mm16;
        ar = e.inst ? rco10 : rco16;
        n_vec++;
        if (aq !== e.q || am !== e.mm || ar !== e.rco) begin
            n_err++;
            $display("FAIL %s: got q=%0d max_min=%b rco=%b, required q=%0d max_min=%b rco=%b",
                     e.name, aq, am, ar, e.q, e.mm, e.rco);
        end
    endtask

    // Drive one cycle of inputs, queue the post-edge expectation, check it #1 after the edge.
    task automatic apply(input logic inst, input logic ld, input logic ce, input logic dn,
                         input logic [3:0] dd, input logic [3:0] eq,
                         input logic em, input logic er, input string nm);
        exp_t e;
        load = ld; cten = ce; down = dn; d = dd;
        e.inst = inst; e.q = eq; e.mm = em; e.rco = er; e.name = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] m;
        logic       ld, ce, dn, em;
        logic [3:0] dd;

        // directed vectors: inst, load, cten, down, d -> q, max_min, rco
        tbl[0]  = mk(1'b0, 1, 1, 0, 4'hA, 4'd10, 0, 0);  // load beats count
        tbl[1]  = mk(1'b0, 0, 1, 0, 4'h0, 4'd11, 0, 0);
        tbl[2]  = mk(1'b1, 1, 1, 1, 4'd1, 4'd1,  0, 0);  // down wrap, mod 10
        tbl[3]  = mk(1'b1, 0, 1, 1, 4'd0, 4'd0,  1, 1);
        tbl[4]  = mk(1'b1, 0, 1, 1, 4'd0, 4'd9,  0, 0);
        tbl[5]  = mk(1'b1, 0, 1, 1, 4'd0, 4'd8,  0, 0);
        tbl[6]  = mk(1'b1, 1, 0, 1, 4'd1, 4'd1,  0, 0);
        tbl[7]  = mk(1'b1, 0, 1, 1, 4'd0, 4'd0,  1, 1);
        tbl[8]  = mk(1'b1, 0, 0, 1, 4'd0, 4'd0,  1, 0);  // terminal but disabled
        tbl[9]  = mk(1'b1, 1, 0, 0, 4'd12, 4'd12, 0, 0); // out-of-range load
        tbl[10] = mk(1'b1, 0, 1, 0, 4'd0, 4'd0,  0, 0);
        tbl[11] = mk(1'b1, 1, 1, 1, 4'd12, 4'd12, 0, 0);
        tbl[12] = mk(1'b1, 0, 1, 1, 4'd0, 4'd11, 0, 0);
        tbl[13] = mk(1'b1, 0, 1, 1, 4'd0, 4'd10, 0, 0);
        tbl[14] = mk(1'b1, 0, 1, 1, 4'd0, 4'd9,  0, 0);
        tbl[15] = mk(1'b1, 0, 0, 0, 4'd0, 4'd9,  1, 0);
        tbl[16] = mk(1'b1, 0, 1, 0, 4'd0, 4'd0,  0, 0);
        tbl[17] = mk(1'b1, 1, 0, 0, 4'd5, 4'd5,  0, 0);  // hold with direction toggling
        tbl[18] = mk(1'b1, 0, 0, 1, 4'd0, 4'd5,  0, 0);
        tbl[19] = mk(1'b1, 0, 0, 0, 4'd0, 4'd5,  0, 0);
        tbl[20] = mk(1'b1, 0, 0, 1, 4'd0, 4'd5,  0, 0);
        tbl[21] = mk(1'b1, 0, 0, 0, 4'd0, 4'd5,  0, 0);
        tbl[22] = mk(1'b0, 1, 1, 0, 4'hF, 4'd15, 1, 1);
        tbl[23] = mk(1'b0, 0, 1, 0, 4'h0, 4'd0,  0, 0);
        tbl[24] = mk(1'b0, 0, 1, 1, 4'h0, 4'd15, 0, 0);

        rst = 1'b1; load = 1'b0; cten = 1'b0; down = 1'b0; d = 4'd0;
        #2;
        chk1("reset_q", q16, 4'd0);
        chk1("reset_mm_up", {3'b0, mm16}, 4'd0);
        chk1("reset_rco_up", {3'b0, rco16}, 4'd0);
        down = 1'b1; cten = 1'b1;
        #1;
        chk1("reset_mm_down", {3'b0, mm16}, 4'd1);
        chk1("reset_rco_down", {3'b0, rco16}, 4'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk1("reset_hold_q", q16, 4'd0);
        end
        rst = 1'b0; cten = 1'b0; down = 1'b0;

        for (int i = 1; i <= 17; i++) begin
            logic [3:0] eq;
            eq = 4'(i % 16);
            em = (eq == 4'd15);
            apply(1'b0, 0, 1, 0, 4'd0, eq, em, em, "up_wrap16");
        end

        for (int i = 0; i < 25; i++) begin
            apply(tbl[i].inst, tbl[i].load, tbl[i].cten, tbl[i].down, tbl[i].d,
                  tbl[i].q, tbl[i].mm, tbl[i].rco, $sformatf("vec%0d", i));
            if (i == 21) chk1("and_array_y", q10 & 4'hF, 4'h5);
        end

        // random traffic on the mod-10 instance against a reference model
        m = 4'd0;
        for (int i = 0; i < 60; i++) begin
            ld = (i == 0) || ($urandom_range(0, 3) == 0);
            ce = 1'($urandom_range(0, 1));
            dn = 1'($urandom_range(0, 1));
            dd = 4'($urandom_range(0, 15));
            if (ld)           m = dd;
            else if (ce && dn) m = (m == 4'd0) ? 4'd9 : m - 4'd1;
            else if (ce)       m = (m >= 4'd9) ? 4'd0 : m + 4'd1;
            em = dn ? (m == 4'd0) : (m == 4'd9);
            apply(1'b1, ld, ce, dn, dd, m, em, em & ce, "random10");
        end

        // asynchronous reset in the middle of a count
        apply(1'b1, 1, 0, 0, 4'd8, 4'd8, 0, 0, "pre_reset_load");
        apply(1'b1, 0, 1, 0, 4'd0, 4'd9, 1, 1, "pre_reset_count");
        #3;
        rst = 1'b1;
        #1;
        chk1("async_reset_q10", q10, 4'd0);
        chk1("async_reset_mm10", {3'b0, mm10}, 4'd0);
        down = 1'b1;
        #1;
        chk1("async_reset_mm10_down", {3'b0, mm10}, 4'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk1("reset_hold_q10", q10, 4'd0);
        end
        rst = 1'b0;
        apply(1'b1, 0, 0, 0, 4'd0, 4'd0, 0, 0, "post_reset_hold");
        apply(1'b1, 0, 1, 0, 4'd0, 4'd1, 0, 0, "post_reset_count");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
